// File: rtl/cjb_dm_arbiter.sv
// cjb_dm_arbiter
// Two-requester arbiter/sequencer for the single-port synchronous data memory.
// The CPU port has fixed priority. After STARVE_LIMIT consecutive CPU wins with
// dma_req pending, the DMA port wins the next decision. DMA writes at or above
// IO_BASE are squashed: the DM is not written and dma_err is raised with the ack.
//
// Access sequence: IDLE/CAP (decide) -> ACC (DM sees addr/we/wdata) -> CAP
// (dm_rdata valid, ack + rdata on next edge, and the next decision is taken).
//
// Ports:
//   Clock, Reset                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata        CPU request (level, held until cpu_gnt)
//   cpu_gnt, cpu_ack, cpu_rdata  grant pulse, completion pulse, read data
//   dma_req/we/addr/wdata        DMA request (level, held until dma_gnt)
//   dma_gnt, dma_ack, dma_rdata  grant pulse, completion pulse, read data
//   dma_err                      pulses with dma_ack when a DMA write was blocked
//   dm_addr, dm_wdata, dm_we     registered DM controls
//   dm_rdata                     DM read data, one cycle after the address
// Optional (macro CJB_DM_ARB_STATS_EN):
//   cpu_grants, dma_grants, blocked_writes   saturating event counters
module cjb_dm_arbiter #(
  parameter int              AW           = 10,
  parameter int              DW           = 8,
  parameter logic [AW-1:0]   IO_BASE      = 10'h3FC,
  parameter int              STARVE_LIMIT = 3
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_err,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic          dm_we,
`ifdef CJB_DM_ARB_STATS_EN
  output logic [15:0]   cpu_grants,
  output logic [15:0]   dma_grants,
  output logic [7:0]    blocked_writes,
`endif
  input  logic [DW-1:0] dm_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACC, CAP} state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

  state_t        state_reg, state_next;
  owner_t        owner_reg, owner_next;
  logic [3:0]    starve_reg, starve_next;
  logic [AW-1:0] dm_addr_reg, dm_addr_next;
  logic [DW-1:0] dm_wdata_reg, dm_wdata_next;
  logic          dm_we_reg, dm_we_next;
  logic          is_read_reg, is_read_next;
  logic          blocked_reg, blocked_next;
  logic          cpu_gnt_reg, cpu_gnt_next;
  logic          dma_gnt_reg, dma_gnt_next;
  logic          cpu_ack_reg, cpu_ack_next;
  logic          dma_ack_reg, dma_ack_next;
  logic          dma_err_reg, dma_err_next;
  logic [DW-1:0] cpu_rdata_reg, cpu_rdata_next;
  logic [DW-1:0] dma_rdata_reg, dma_rdata_next;

  logic decide;
  logic dma_in_io;
  logic dma_wins;

  assign decide    = (state_reg == IDLE) || (state_reg == CAP);
  assign dma_in_io = (dma_addr >= IO_BASE);
  // Starved DMA beats the CPU; otherwise DMA only wins when the CPU is quiet.
  assign dma_wins  = dma_req && ((starve_reg == LIMIT) || !cpu_req);

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    starve_next    = starve_reg;
    dm_addr_next   = dm_addr_reg;
    dm_wdata_next  = dm_wdata_reg;
    dm_we_next     = dm_we_reg;
    is_read_next   = is_read_reg;
    blocked_next   = blocked_reg;
    cpu_gnt_next   = 1'b0;
    dma_gnt_next   = 1'b0;
    cpu_ack_next   = 1'b0;
    dma_ack_next   = 1'b0;
    dma_err_next   = 1'b0;
    cpu_rdata_next = cpu_rdata_reg;
    dma_rdata_next = dma_rdata_reg;

    case (state_reg)
      ACC: begin
        dm_we_next = 1'b0;
        state_next = CAP;
      end
      CAP: begin
        // Complete the access in flight; rdata only updates on reads.
        if (owner_reg == OWN_DMA) begin
          dma_ack_next = 1'b1;
          dma_err_next = blocked_reg;
          if (is_read_reg) dma_rdata_next = dm_rdata;
        end else begin
          cpu_ack_next = 1'b1;
          if (is_read_reg) cpu_rdata_next = dm_rdata;
        end
      end
      default: ;
    endcase

    if (decide) begin
      if (dma_wins) begin
        owner_next    = OWN_DMA;
        dm_addr_next  = dma_addr;
        dm_wdata_next = dma_wdata;
        dm_we_next    = dma_we && !dma_in_io;
        is_read_next  = !dma_we;
        blocked_next  = dma_we && dma_in_io;
        dma_gnt_next  = 1'b1;
        starve_next   = 4'd0;
        state_next    = ACC;
      end else if (cpu_req) begin
        owner_next    = OWN_CPU;
        dm_addr_next  = cpu_addr;
        dm_wdata_next = cpu_wdata;
        dm_we_next    = cpu_we;
        is_read_next  = !cpu_we;
        blocked_next  = 1'b0;
        cpu_gnt_next  = 1'b1;
        state_next    = ACC;
        if (!dma_req)
          starve_next = 4'd0;
        else if (starve_reg != LIMIT)
          starve_next = starve_reg + 4'd1;
      end else begin
        starve_next = 4'd0;
        state_next  = IDLE;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_CPU;
      starve_reg    <= 4'd0;
      dm_addr_reg   <= '0;
      dm_wdata_reg  <= '0;
      dm_we_reg     <= 1'b0;
      is_read_reg   <= 1'b0;
      blocked_reg   <= 1'b0;
      cpu_gnt_reg   <= 1'b0;
      dma_gnt_reg   <= 1'b0;
      cpu_ack_reg   <= 1'b0;
      dma_ack_reg   <= 1'b0;
      dma_err_reg   <= 1'b0;
      cpu_rdata_reg <= '0;
      dma_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      starve_reg    <= starve_next;
      dm_addr_reg   <= dm_addr_next;
      dm_wdata_reg  <= dm_wdata_next;
      dm_we_reg     <= dm_we_next;
      is_read_reg   <= is_read_next;
      blocked_reg   <= blocked_next;
      cpu_gnt_reg   <= cpu_gnt_next;
      dma_gnt_reg   <= dma_gnt_next;
      cpu_ack_reg   <= cpu_ack_next;
      dma_ack_reg   <= dma_ack_next;
      dma_err_reg   <= dma_err_next;
      cpu_rdata_reg <= cpu_rdata_next;
      dma_rdata_reg <= dma_rdata_next;
    end
  end

  assign cpu_gnt   = cpu_gnt_reg;
  assign cpu_ack   = cpu_ack_reg;
  assign cpu_rdata = cpu_rdata_reg;
  assign dma_gnt   = dma_gnt_reg;
  assign dma_ack   = dma_ack_reg;
  assign dma_rdata = dma_rdata_reg;
  assign dma_err   = dma_err_reg;
  assign dm_addr   = dm_addr_reg;
  assign dm_wdata  = dm_wdata_reg;
  assign dm_we     = dm_we_reg;

`ifdef CJB_DM_ARB_STATS_EN
  logic [15:0] cpu_grants_reg;
  logic [15:0] dma_grants_reg;
  logic [7:0]  blocked_writes_reg;

  // The *_gnt_next strobes mark exactly the decision edges with a winner.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cpu_grants_reg     <= '0;
      dma_grants_reg     <= '0;
      blocked_writes_reg <= '0;
    end else begin
      if (cpu_gnt_next && (cpu_grants_reg != 16'hFFFF))
        cpu_grants_reg <= cpu_grants_reg + 16'd1;
      if (dma_gnt_next && (dma_grants_reg != 16'hFFFF))
        dma_grants_reg <= dma_grants_reg + 16'd1;
      if (dma_gnt_next && blocked_next && (blocked_writes_reg != 8'hFF))
        blocked_writes_reg <= blocked_writes_reg + 8'd1;
    end
  end

  assign cpu_grants     = cpu_grants_reg;
  assign dma_grants     = dma_grants_reg;
  assign blocked_writes = blocked_writes_reg;
`endif

endmodule

// File: tb/tb_cjb_dm_arbiter.sv
// Testbench for cjb_dm_arbiter: directed scenarios followed by randomized
// traffic on both ports, checked every cycle against a transaction-level model
// (decision points, starvation streak, expected memory contents).
module tb_cjb_dm_arbiter;
  localparam int         AW      = 10;
  localparam int         DW      = 8;
  localparam logic [9:0] IO_BASE = 10'h3FC;
  localparam int         LIMIT   = 3;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_gnt, dma_ack, dma_err;
  logic [DW-1:0] dma_rdata;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_we;
  logic [DW-1:0] dm_rdata;
`ifdef CJB_DM_ARB_STATS_EN
  logic [15:0]   cpu_grants, dma_grants;
  logic [7:0]    blocked_writes;
`endif

  always #5 Clock = ~Clock;

  cjb_dm_arbiter #(.AW(AW), .DW(DW), .IO_BASE(IO_BASE), .STARVE_LIMIT(LIMIT)) dut (
    .Clock(Clock), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
`ifdef CJB_DM_ARB_STATS_EN
    .cpu_grants(cpu_grants), .dma_grants(dma_grants), .blocked_writes(blocked_writes),
`endif
    .dm_rdata(dm_rdata)
  );

  // Synchronous single-port data memory.
  logic [DW-1:0] dm_mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) dm_mem[i] = '0;
    dm_mem[16] = 8'hA5;
    forever begin
      @(posedge Clock);
      dm_rdata <= dm_mem[dm_addr];
      if (dm_we) dm_mem[dm_addr] <= dm_wdata;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    else
      n_pass++;
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] mem_ref [0:1023];
  int            free_at, streak, ack_due;
  bit            ack_dma, ack_read, ack_err;
  logic [DW-1:0] ack_data;
  logic          e_cpu_gnt, e_dma_gnt, e_cpu_ack, e_dma_ack, e_err, e_dm_we;
  logic [AW-1:0] e_dm_addr;
  logic [DW-1:0] e_dm_wdata, e_cpu_rdata, e_dma_rdata;
  int            m_cpu_grants, m_dma_grants, m_blocked;
  byte           grant_log[$];

  task automatic model_step();
    int            w;
    bit            we, blk;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    cyc++;
    if (Reset) begin
      {e_cpu_gnt, e_dma_gnt, e_cpu_ack, e_dma_ack, e_err, e_dm_we} = '0;
      e_dm_addr = '0; e_dm_wdata = '0; e_cpu_rdata = '0; e_dma_rdata = '0;
      free_at = cyc + 1; streak = 0; ack_due = -1;
      m_cpu_grants = 0; m_dma_grants = 0; m_blocked = 0;
      return;
    end
    {e_cpu_gnt, e_dma_gnt, e_cpu_ack, e_dma_ack, e_err, e_dm_we} = '0;
    if (ack_due == cyc) begin
      if (ack_dma) begin
        e_dma_ack = 1'b1; e_err = ack_err;
        if (ack_read) e_dma_rdata = ack_data;
      end else begin
        e_cpu_ack = 1'b1;
        if (ack_read) e_cpu_rdata = ack_data;
      end
      ack_due = -1;
    end
    if (cyc >= free_at) begin
      if (dma_req && streak == LIMIT) w = 2;
      else if (cpu_req)               w = 1;
      else if (dma_req)               w = 2;
      else                            w = 0;
      if (w == 0) begin
        streak = 0; free_at = cyc + 1;
      end else begin
        we  = (w == 2) ? dma_we : cpu_we;
        a   = (w == 2) ? dma_addr : cpu_addr;
        d   = (w == 2) ? dma_wdata : cpu_wdata;
        blk = (w == 2) && we && (a >= IO_BASE);
        if (w == 2) streak = 0;
        else if (!dma_req) streak = 0;
        else if (streak < LIMIT) streak++;
        e_cpu_gnt = (w == 1); e_dma_gnt = (w == 2);
        e_dm_addr = a; e_dm_wdata = d; e_dm_we = we && !blk;
        ack_due = cyc + 2; ack_dma = (w == 2); ack_read = !we;
        ack_data = mem_ref[a]; ack_err = blk;
        if (we && !blk) mem_ref[a] = d;
        free_at = cyc + 2;
        if (w == 1 && m_cpu_grants < 65535) m_cpu_grants++;
        if (w == 2 && m_dma_grants < 65535) m_dma_grants++;
        if (blk && m_blocked < 255) m_blocked++;
        grant_log.push_back((w == 2) ? 8'h44 : 8'h43);
        $display("cyc %0d grant %s we=%0d addr=%h wdata=%h%s", cyc,
                 (w == 2) ? "DMA" : "CPU", we, a, d, blk ? " blocked" : "");
      end
    end
  endtask

  task automatic check_outputs();
    chk("cpu_gnt",   32'(cpu_gnt),   32'(e_cpu_gnt));
    chk("dma_gnt",   32'(dma_gnt),   32'(e_dma_gnt));
    chk("cpu_ack",   32'(cpu_ack),   32'(e_cpu_ack));
    chk("dma_ack",   32'(dma_ack),   32'(e_dma_ack));
    chk("dma_err",   32'(dma_err),   32'(e_err));
    chk("dm_we",     32'(dm_we),     32'(e_dm_we));
    chk("dm_addr",   32'(dm_addr),   32'(e_dm_addr));
    chk("dm_wdata",  32'(dm_wdata),  32'(e_dm_wdata));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(e_cpu_rdata));
    chk("dma_rdata", 32'(dma_rdata), 32'(e_dma_rdata));
`ifdef CJB_DM_ARB_STATS_EN
    chk("cpu_grants",     32'(cpu_grants),     32'(m_cpu_grants));
    chk("dma_grants",     32'(dma_grants),     32'(m_dma_grants));
    chk("blocked_writes", 32'(blocked_writes), 32'(m_blocked));
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_ref[i] = '0;
    mem_ref[16] = 8'hA5;
    forever begin
      @(posedge Clock);
      model_step();
      #1;
      check_outputs();
    end
  end

  // ---------------- stimulus ----------------
  task automatic access(input bit dma, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    bit got = 0;
    @(negedge Clock);
    if (dma) begin dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = d; end
    else     begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clock);
      if (dma ? dma_gnt : cpu_gnt) got = 1;
    end
    if (dma) dma_req = 0; else cpu_req = 0;
    if (!got) chk("gnt_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge Clock);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 5) == 0) return IO_BASE + 10'($urandom_range(0, 3));
    return 10'($urandom_range(0, 15));
  endfunction

  task automatic random_phase(input int ncyc, input int cpu_pct, input int dma_pct);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge Clock);
      if (!cpu_req || cpu_gnt) begin
        cpu_req   = ($urandom_range(0, 99) < cpu_pct);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = rand_addr();
        cpu_wdata = 8'($urandom);
      end
      if (!dma_req || dma_gnt) begin
        dma_req   = ($urandom_range(0, 99) < dma_pct);
        dma_we    = 1'($urandom_range(0, 1));
        dma_addr  = rand_addr();
        dma_wdata = 8'($urandom);
      end
    end
    @(negedge Clock);
    cpu_req = 0; dma_req = 0;
    repeat (4) @(negedge Clock);
  endtask

  byte exp_order[8] = '{8'h43, 8'h43, 8'h43, 8'h44, 8'h43, 8'h43, 8'h43, 8'h44};

  initial begin
    bit got;
    repeat (3) @(negedge Clock);
    Reset = 0;
    repeat (2) @(negedge Clock);

    // CPU read of preloaded word, then CPU write
    access(0, 0, 10'h010, 8'h00);
    chk("read_a5", 32'(cpu_rdata), 32'h0000_00A5);
    access(0, 1, 10'h020, 8'h3C);
    chk("write_holds_rdata", 32'(cpu_rdata), 32'h0000_00A5);

    // Both ports held: starvation rotation C,C,C,D,C,C,C,D
    @(negedge Clock);
    grant_log.delete();
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h040;
    dma_req = 1; dma_we = 0; dma_addr = 10'h041;
    for (int i = 0; i < 40 && grant_log.size() < 8; i++) @(negedge Clock);
    cpu_req = 0; dma_req = 0;
    chk("order_count", 32'(grant_log.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk("order", 32'(grant_log[i]), 32'(exp_order[i]));
    repeat (4) @(negedge Clock);

    // DMA write into the I/O window is squashed; read of it is allowed
    access(1, 1, 10'h3FD, 8'h77);
    chk("io_not_written", 32'(dm_mem[10'h3FD]), 32'd0);
    access(1, 0, 10'h3FD, 8'h00);

    // Reset during ACC of a DMA write
    @(negedge Clock);
    dma_req = 1; dma_we = 1; dma_addr = 10'h030; dma_wdata = 8'h5A;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clock);
      if (dma_gnt) got = 1;
    end
    if (!got) chk("gnt_timeout", 32'd0, 32'd1);
    Reset = 1; dma_req = 0;
    @(negedge Clock);
    Reset = 0;
    chk("reset_dm_we", 32'(dm_we), 32'd0);
    repeat (2) @(negedge Clock);
    access(0, 0, 10'h030, 8'h00);
    chk("after_reset_read", 32'(cpu_rdata), 32'h0000_005A);

    // Randomized traffic at several load mixes
    random_phase(300, 70, 30);
    random_phase(300, 30, 80);
    random_phase(300, 90, 90);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cjb_dm_arbiter.md
Name: cjb_dm_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port synchronous data memory (DM) of the cjbRISC_HMMIOP.
- Shares the DM between the CPU data path (MAR/RW side) and a DMA/program-loader port.
- CPU has fixed priority, with a starvation limit that guarantees the DMA port a slot.
- Also blocks DMA writes into the memory-mapped I/O window at the top of the address space.

Parameters:
AW, 10, address width (matches MAR)
DW, 8, data width
IO_BASE, 10'h3FC, first address of the I/O window; DMA writes at or above this address are blocked
STARVE_LIMIT, 3, consecutive CPU grants allowed while dma_req is pending (range 1..15)

Ports:
Clock  in  1  clock, all state changes on rising edge
Reset  in  1  synchronous, active-high
cpu_req  in  1  CPU access request, level
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  one-cycle pulse: CPU request accepted
cpu_ack  out  1  one-cycle pulse: CPU access complete, cpu_rdata valid
cpu_rdata  out  DW  registered read data for CPU
dma_req, dma_we, dma_addr, dma_wdata  in  1/1/AW/DW  same meaning for the DMA port
dma_gnt, dma_ack  out  1  same meaning for the DMA port
dma_rdata  out  DW  registered read data for DMA
dma_err  out  1  pulses with dma_ack when a DMA write was blocked
dm_addr  out  AW  DM address, registered
dm_wdata  out  DW  DM write data, registered
dm_we  out  1  DM write enable (RW), registered
dm_rdata  in  DW  DM read data, valid one cycle after the address is sampled

Behaviour:
- Reset is synchronous; Clock only.
- Reset values: all outputs 0, state IDLE, owner CPU, starvation counter 0.
- States:
  - IDLE: evaluate requests.
  - ACC: latched address, write data and we drive the DM; xx_gnt is 1 for the owner.
  - CAP: dm_rdata is valid; evaluate requests again.
- Arbitration happens only at the edge leaving IDLE or CAP:
  - dma_req & (starve_cnt == STARVE_LIMIT): DMA wins.
  - else cpu_req: CPU wins.
  - else dma_req: DMA wins.
  - else: go to IDLE.
- On a win, the winner's we/addr/wdata are latched into the dm_* registers and the state becomes ACC. The owner is recorded.
- Starvation counter:
  - Increments on each CPU win while dma_req = 1.
  - Clears on a DMA win, or at a decision edge with dma_req = 0.
  - Saturates at STARVE_LIMIT.
- Handshake:
  - The requester holds req/we/addr/wdata stable until it sees gnt.
  - In the gnt cycle the requester may drop req or present the next request. Req is not sampled in ACC.
- Edge leaving ACC:
  - dm_we is cleared.
  - State goes to CAP.
- Edge leaving CAP:
  - The owner's xx_rdata is loaded with dm_rdata on reads only; on writes it holds.
  - The owner's xx_ack is set for exactly the next cycle.
  - The next arbitration decision is taken at the same edge.
- Latency:
  - Request seen at edge E0, gnt high in cycle E0..E1, ack high in cycle E2..E3.
  - Back-to-back throughput: one access every 2 cycles.
- DMA write with dma_addr >= IO_BASE:
  - Latched with dm_we forced to 0, so the DM is not written.
  - The normal ack is given, with dma_err = 1 in the ack cycle.
  - DMA reads of that window are allowed.
  - CPU accesses are never blocked, because the CU routes I/O itself.
- Simultaneous requests: resolved by the priority rule above. The loser's request stays pending with no gnt.
- Reset mid-access: next state is IDLE and all pulses/outputs return to 0. The in-flight access gets no ack, and dm_we is 0 from the following cycle.
- Address arithmetic: no incrementing or wrap; addresses pass through unchanged at AW bits.

Optional Feature:
CJB_DM_ARB_STATS_EN: adds outputs cpu_grants[15:0], dma_grants[15:0] and blocked_writes[7:0].
- Each is a saturating counter incremented at the corresponding win or block.
- Cleared by Reset.
- Without the macro the ports and logic do not exist, and the arbiter behaves identically otherwise.

Test Plan:
1. Reset, then CPU read of addr 10'h010 with DM holding 8'hA5 → cpu_gnt in cycle 1, dm_addr = 10'h010 with dm_we = 0, cpu_ack in cycle 3 with cpu_rdata = 8'hA5.
2. CPU write 8'h3C to 10'h020 → dm_we = 1 for exactly one cycle with dm_wdata = 8'h3C; cpu_ack follows 2 cycles after gnt; cpu_rdata unchanged.
3. cpu_req and dma_req held high together, STARVE_LIMIT = 3 → grant order C,C,C,D,C,C,C,D; no gnt lost or duplicated.
4. DMA write to 10'h3FD → dm_we stays 0; dma_ack and dma_err both high in the same cycle. DMA read of 10'h3FD completes normally with dma_err = 0.
5. Reset asserted during ACC of a DMA write → no dma_ack, dm_we = 0 the next cycle, state IDLE; a fresh CPU request afterwards completes normally.
6. With CJB_DM_ARB_STATS_EN defined, scenario 3 run for 8 grants → cpu_grants = 6, dma_grants = 2.
